// File: rtl/wb_sram_bridge.sv
// Wishbone slave bridging the management bus onto two 32x512 SRAM macros (port 0).
// Ports: clk_i/rst_i, wbs_* Wishbone slave, o_csb/o_web/o_wmask/o_waddr/o_din and
// i_dout per bank (suffix 0 = adr[11] low, suffix 1 = adr[11] high).
module wb_sram_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_F000,
    parameter int          AW        = 9,
    parameter int          READ_WAIT = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wbs_cyc_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_adr_i,
    input  logic [31:0]   wbs_dat_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,
    output logic          o_csb0,
    output logic          o_web0,
    output logic [3:0]    o_wmask0,
    output logic [AW-1:0] o_waddr0,
    output logic [31:0]   o_din0,
    input  logic [31:0]   i_dout0,
    output logic          o_csb1,
    output logic          o_web1,
    output logic [3:0]    o_wmask1,
    output logic [AW-1:0] o_waddr1,
    output logic [31:0]   o_din1,
    input  logic [31:0]   i_dout1
);

    typedef enum logic [1:0] {IDLE, RWAIT, ACK} state_t;

    localparam logic [1:0] RW_INIT = 2'(READ_WAIT);

    state_t        state, state_nx;
    logic [1:0]    cnt, cnt_nx;
    logic          bank, bank_nx;
    logic          we_q, we_nx;
    logic          miss_q, miss_nx;

    logic          ack_nx;
    logic [31:0]   dat_nx;
    logic          csb0_nx, csb1_nx;
    logic          web0_nx, web1_nx;
    logic [3:0]    wmask0_nx, wmask1_nx;
    logic [AW-1:0] waddr0_nx, waddr1_nx;
    logic [31:0]   din0_nx, din1_nx;

    logic          req;
    logic          hit;
    logic [AW-1:0] word;

    assign req  = wbs_cyc_i & wbs_stb_i;
    assign hit  = ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
    assign word = wbs_adr_i[2 +: AW];

    // State and all registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            bank      <= 1'b0;
            we_q      <= 1'b0;
            miss_q    <= 1'b0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            o_csb0    <= 1'b1;
            o_web0    <= 1'b1;
            o_wmask0  <= '0;
            o_waddr0  <= '0;
            o_din0    <= '0;
            o_csb1    <= 1'b1;
            o_web1    <= 1'b1;
            o_wmask1  <= '0;
            o_waddr1  <= '0;
            o_din1    <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            bank      <= bank_nx;
            we_q      <= we_nx;
            miss_q    <= miss_nx;
            wbs_ack_o <= ack_nx;
            wbs_dat_o <= dat_nx;
            o_csb0    <= csb0_nx;
            o_web0    <= web0_nx;
            o_wmask0  <= wmask0_nx;
            o_waddr0  <= waddr0_nx;
            o_din0    <= din0_nx;
            o_csb1    <= csb1_nx;
            o_web1    <= web1_nx;
            o_wmask1  <= wmask1_nx;
            o_waddr1  <= waddr1_nx;
            o_din1    <= din1_nx;
        end
    end

    // Next-state logic; ACK is entered with ack low for writes and misses,
    // and with ack already high for reads coming out of RWAIT.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (req) begin
                    state_nx = (hit && !wbs_we_i) ? RWAIT : ACK;
                end
            end
            RWAIT: begin
                if (cnt == 2'd0) begin
                    state_nx = wbs_cyc_i ? ACK : IDLE;
                end
            end
            ACK: begin
                if (wbs_ack_o || !wbs_cyc_i) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output logic; chip selects and write enables default high so each
    // command is presented to the macro for exactly one cycle.
    always_comb begin
        cnt_nx    = cnt;
        bank_nx   = bank;
        we_nx     = we_q;
        miss_nx   = miss_q;
        ack_nx    = 1'b0;
        dat_nx    = wbs_dat_o;
        csb0_nx   = 1'b1;
        web0_nx   = 1'b1;
        wmask0_nx = o_wmask0;
        waddr0_nx = o_waddr0;
        din0_nx   = o_din0;
        csb1_nx   = 1'b1;
        web1_nx   = 1'b1;
        wmask1_nx = o_wmask1;
        waddr1_nx = o_waddr1;
        din1_nx   = o_din1;
        unique case (state)
            IDLE: begin
                if (req) begin
                    we_nx   = wbs_we_i;
                    miss_nx = !hit;
                    cnt_nx  = RW_INIT;
                    if (hit) begin
                        bank_nx = wbs_adr_i[11];
                        if (!wbs_adr_i[11]) begin
                            csb0_nx   = 1'b0;
                            web0_nx   = !wbs_we_i;
                            wmask0_nx = wbs_we_i ? wbs_sel_i : 4'b0000;
                            waddr0_nx = word;
                            din0_nx   = wbs_dat_i;
                        end else begin
                            csb1_nx   = 1'b0;
                            web1_nx   = !wbs_we_i;
                            wmask1_nx = wbs_we_i ? wbs_sel_i : 4'b0000;
                            waddr1_nx = word;
                            din1_nx   = wbs_dat_i;
                        end
                    end
                end
            end
            RWAIT: begin
                if (cnt == 2'd0) begin
                    if (wbs_cyc_i) begin
                        ack_nx = 1'b1;
                        dat_nx = bank ? i_dout1 : i_dout0;
                    end
                end else begin
                    cnt_nx = cnt - 2'd1;
                end
            end
            ACK: begin
                if (!wbs_ack_o && wbs_cyc_i) begin
                    ack_nx = 1'b1;
                    // Out-of-window reads return zero
                    if (miss_q && !we_q) begin
                        dat_nx = '0;
                    end
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Directed testbench for wb_sram_bridge: behavioural SRAM models behind the
// main instance (READ_WAIT=1) and two extra instances for READ_WAIT=2 and 3.
module tb_wb_sram_bridge;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cyc, cyc_b, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;

    logic        ack;
    logic [31:0] dat_o;
    logic        o_csb0, o_web0, o_csb1, o_web1;
    logic [3:0]  o_wmask0, o_wmask1;
    logic [8:0]  o_waddr0, o_waddr1;
    logic [31:0] o_din0, o_din1;
    logic [31:0] dout0, dout1;

    logic [31:0] mem0 [512];
    logic [31:0] mem1 [512];

    int n_pass = 0;
    int n_fail = 0;
    int n_tot  = 0;

    int          r_lat, r_cs0, r_cs1, r_web, r_acks;
    logic [3:0]  r_wm;
    logic [8:0]  r_wa;
    logic [31:0] r_dat;

    wb_sram_bridge #(.READ_WAIT(1)) dut (
        .clk_i(clk), .rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .o_csb0(o_csb0), .o_web0(o_web0), .o_wmask0(o_wmask0),
        .o_waddr0(o_waddr0), .o_din0(o_din0), .i_dout0(dout0),
        .o_csb1(o_csb1), .o_web1(o_web1), .o_wmask1(o_wmask1),
        .o_waddr1(o_waddr1), .o_din1(o_din1), .i_dout1(dout1)
    );

    // Macro model: inputs captured on the rising edge, read data registered
    always @(posedge clk) begin
        if (!o_csb0) begin
            if (!o_web0) begin
                for (int b = 0; b < 4; b++)
                    if (o_wmask0[b]) mem0[o_waddr0][8*b +: 8] <= o_din0[8*b +: 8];
            end else begin
                dout0 <= mem0[o_waddr0];
            end
        end
        if (!o_csb1) begin
            if (!o_web1) begin
                for (int b = 0; b < 4; b++)
                    if (o_wmask1[b]) mem1[o_waddr1][8*b +: 8] <= o_din1[8*b +: 8];
            end else begin
                dout1 <= mem1[o_waddr1];
            end
        end
    end

    // READ_WAIT sweep instances
    logic        ack2, ack3;
    logic [31:0] dat2, dat3;
    logic        c2a, w2a, c2b, w2b, c3a, w3a, c3b, w3b;
    logic [3:0]  m2a, m2b, m3a, m3b;
    logic [8:0]  a2a, a2b, a3a, a3b;
    logic [31:0] d2a, d2b, d3a, d3b;

    wb_sram_bridge #(.READ_WAIT(2)) dut2 (
        .clk_i(clk), .rst_i(rst),
        .wbs_cyc_i(cyc_b), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_ack_o(ack2), .wbs_dat_o(dat2),
        .o_csb0(c2a), .o_web0(w2a), .o_wmask0(m2a),
        .o_waddr0(a2a), .o_din0(d2a), .i_dout0(32'h2222_0002),
        .o_csb1(c2b), .o_web1(w2b), .o_wmask1(m2b),
        .o_waddr1(a2b), .o_din1(d2b), .i_dout1(32'h2222_1112)
    );

    wb_sram_bridge #(.READ_WAIT(3)) dut3 (
        .clk_i(clk), .rst_i(rst),
        .wbs_cyc_i(cyc_b), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_ack_o(ack3), .wbs_dat_o(dat3),
        .o_csb0(c3a), .o_web0(w3a), .o_wmask0(m3a),
        .o_waddr0(a3a), .o_din0(d3a), .i_dout0(32'h3333_0003),
        .o_csb1(c3b), .o_web1(w3b), .o_wmask1(m3b),
        .o_waddr1(a3b), .o_din1(d3b), .i_dout1(32'h3333_1113)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One Wishbone transfer; latency counted in edges from the accept edge (1)
    task automatic xfer(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
        r_lat = -1; r_cs0 = 0; r_cs1 = 0; r_web = 0; r_acks = 0;
        r_wm = 4'hE; r_wa = 9'h1FF; r_dat = 32'hDEAD_BEEF;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (!o_csb0) begin r_cs0++; r_wm = o_wmask0; r_wa = o_waddr0; end
            if (!o_csb1) begin r_cs1++; r_wm = o_wmask1; r_wa = o_waddr1; end
            if (!o_web0 || !o_web1) r_web++;
            if (ack) begin
                r_acks++;
                if (r_lat < 0) begin r_lat = i; r_dat = dat_o; end
                cyc = 1'b0; stb = 1'b0; we = 1'b0;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    int l2, l3, na;
    logic [31:0] v2, v3;

    initial begin
        rst = 1'b1; cyc = 1'b0; cyc_b = 1'b0; stb = 1'b0; we = 1'b0;
        sel = 4'h0; adr = '0; wdat = '0;
        repeat (2) tick();
        chk("rst_csb0", {31'd0, o_csb0}, 32'd1);
        chk("rst_csb1", {31'd0, o_csb1}, 32'd1);
        chk("rst_web",  {30'd0, o_web1, o_web0}, 32'd3);
        chk("rst_ack",  {31'd0, ack}, 32'd0);
        chk("rst_dat",  dat_o, 32'd0);
        chk("rst_cmd",  {o_wmask0, o_waddr0, o_din0[18:0]}, 32'd0);
        rst = 1'b0;
        tick();

        // Bank0 write and readback
        xfer(1'b1, 32'h3000_0010, 32'hA5A5_1234, 4'hF);
        chk("t1w_lat", r_lat, 32'd2);
        chk("t1w_cs",  {r_cs0[15:0], r_cs1[15:0]}, {16'd1, 16'd0});
        chk("t1w_web", r_web, 32'd1);
        chk("t1w_adr", {19'd0, r_wm, r_wa}, {19'd0, 4'hF, 9'd4});
        chk("t1w_acks", r_acks, 32'd1);
        xfer(1'b0, 32'h3000_0010, 32'h0, 4'hF);
        chk("t1r_lat", r_lat, 32'd3);
        chk("t1r_dat", r_dat, 32'hA5A5_1234);
        chk("t1r_cs",  {r_cs0[15:0], r_cs1[15:0]}, {16'd1, 16'd0});
        chk("t1r_web", r_web, 32'd0);
        chk("t1r_acks", r_acks, 32'd1);
        chk("t1r_hold", dat_o, 32'hA5A5_1234);

        // Bank1 at the same word offset
        xfer(1'b1, 32'h3000_0810, 32'h1111_1111, 4'hF);
        chk("t2w_cs",  {r_cs0[15:0], r_cs1[15:0]}, {16'd0, 16'd1});
        chk("t2w_adr", {23'd0, r_wa}, 32'd4);
        chk("t2w_hold", dat_o, 32'hA5A5_1234);
        xfer(1'b0, 32'h3000_0010, 32'h0, 4'hF);
        chk("t2r0_dat", r_dat, 32'hA5A5_1234);
        xfer(1'b0, 32'h3000_0810, 32'h0, 4'hF);
        chk("t2r1_dat", r_dat, 32'h1111_1111);
        chk("t2r1_cs",  {r_cs0[15:0], r_cs1[15:0]}, {16'd0, 16'd1});

        // Partial byte write
        xfer(1'b1, 32'h3000_0020, 32'hFFFF_FFFF, 4'hF);
        xfer(1'b1, 32'h3000_0020, 32'h0000_0000, 4'b0101);
        chk("t3_wmask", {28'd0, r_wm}, 32'h5);
        xfer(1'b0, 32'h3000_0020, 32'h0, 4'hF);
        chk("t3_dat", r_dat, 32'hFF00_FF00);
        xfer(1'b1, 32'h3000_0020, 32'h1234_5678, 4'b0000);
        chk("t3_sel0_lat", r_lat, 32'd2);
        chk("t3_sel0_wm", {28'd0, r_wm}, 32'h0);
        xfer(1'b0, 32'h3000_0020, 32'h0, 4'hF);
        chk("t3_sel0_dat", r_dat, 32'hFF00_FF00);

        // Out-of-window accesses
        xfer(1'b1, 32'h2000_0000, 32'hDEAD_BEEF, 4'hF);
        chk("t4w_lat", r_lat, 32'd2);
        chk("t4w_cs",  r_cs0 + r_cs1, 32'd0);
        chk("t4w_hold", dat_o, 32'hFF00_FF00);
        xfer(1'b0, 32'h3000_1000, 32'h0, 4'hF);
        chk("t4r_lat", r_lat, 32'd2);
        chk("t4r_cs",  r_cs0 + r_cs1, 32'd0);
        chk("t4r_dat", r_dat, 32'd0);
        chk("t4r_acks", r_acks, 32'd1);

        // Asynchronous reset during RWAIT
        xfer(1'b0, 32'h3000_0810, 32'h0, 4'hF);
        chk("t5_pre", dat_o, 32'h1111_1111);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0810;
        tick();
        chk("t5_acc", {31'd0, o_csb1}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("t5_async", {28'd0, o_csb0, o_csb1, o_web0, o_web1}, 32'hF);
        chk("t5_ack", {31'd0, ack}, 32'd0);
        chk("t5_dat", dat_o, 32'd0);
        cyc = 1'b0; stb = 1'b0;
        tick();
        rst = 1'b0;
        na = 0;
        repeat (5) begin tick(); if (ack) na++; end
        chk("t5_noack", na, 32'd0);
        xfer(1'b0, 32'h3000_0810, 32'h0, 4'hF);
        chk("t5_after_lat", r_lat, 32'd3);
        chk("t5_after_dat", r_dat, 32'h1111_1111);

        // Abort by dropping cyc during RWAIT
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0010;
        tick();
        cyc = 1'b0; stb = 1'b0;
        na = 0;
        repeat (6) begin tick(); if (ack) na++; end
        chk("t6_noack", na, 32'd0);
        chk("t6_hold", dat_o, 32'h1111_1111);
        xfer(1'b0, 32'h3000_0020, 32'h0, 4'hF);
        chk("t6_after_lat", r_lat, 32'd3);
        chk("t6_after_dat", r_dat, 32'hFF00_FF00);

        // READ_WAIT sweep on the extra instances
        l2 = -1; l3 = -1; v2 = '0; v3 = '0;
        cyc = 1'b0; cyc_b = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0000;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (ack2 && l2 < 0) begin l2 = i; v2 = dat2; end
            if (ack3 && l3 < 0) begin l3 = i; v3 = dat3; end
        end
        cyc_b = 1'b0; stb = 1'b0;
        repeat (8) tick();
        chk("rw2_lat", l2, 32'd4);
        chk("rw3_lat", l3, 32'd5);
        chk("rw2_dat", v2, 32'h2222_0002);
        chk("rw3_dat", v3, 32'h3333_0003);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
